// File: rtl/xorshift_rr_scheduler_pkg.sv
// Shared types and helpers for the xorshift round-robin scheduler slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default word width and shift amounts, FSM state enum, and the
// single-step xorshift32 helper used by the core datapath.
package xorshift_rr_scheduler_pkg;

    localparam int XS_DATA_W = 32;
    localparam int XS_SH_A   = 13;
    localparam int XS_SH_B   = 17;
    localparam int XS_SH_C   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // One stage of the three-stage xorshift sequence. Shifted-out bits are
    // dropped because the result stays XS_DATA_W bits wide.
    function automatic logic [XS_DATA_W-1:0] xs_step(
        input logic [XS_DATA_W-1:0] d,
        input logic [1:0]           step,
        input int                   sh_a,
        input int                   sh_b,
        input int                   sh_c
    );
        logic [XS_DATA_W-1:0] r;
        r = d;
        case (step)
            2'd0:    r = d ^ (d << sh_a);
            2'd1:    r = d ^ (d >> sh_b);
            2'd2:    r = d ^ (d << sh_c);
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/xorshift_rr_scheduler_if.sv
// Request/response bundle between requesters, the scheduler and the FIFO writer.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the FIFO writer stalls the output stream.
//
// Ports (slave = scheduler side):
//   req_valid/req_seed/req_len  per-requester request, slice i is requester i
//   req_ready                   one-hot grant, accept = valid & ready
//   out_valid/out_data/out_id   random word stream tagged with owner id
//   out_ready                   downstream not full
//   done                        per-requester completion pulse
//   busy                        scheduler is working on a job
interface xorshift_rr_scheduler_if
    import xorshift_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = XS_DATA_W,
    parameter int LEN_W   = 9
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_seed;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      out_ready;
    logic [NUM_REQ-1:0]        done;
    logic                      busy;

    modport slave (
        input  req_valid, req_seed, req_len, out_ready,
        output req_ready, out_valid, out_data, out_id, done, busy
    );

    modport master (
        output req_valid, req_seed, req_len, out_ready,
        input  req_ready, out_valid, out_data, out_id, done, busy
    );

endinterface

// File: rtl/xorshift_rr_scheduler_core.sv
// Shared xorshift32 datapath: data register plus 3-stage step sequencer.
// Latency: one shift per cycle while run is high; step_done flags the third.
// Backpressure: none internally; the owner simply stops asserting run.
//
// Ports: clk, rst (async active-high), load/seed (restart from a seed),
//        run (advance one step), data (current register), step_done.
module xorshift_rr_scheduler_core
    import xorshift_rr_scheduler_pkg::*;
#(
    parameter int DATA_W = XS_DATA_W,
    parameter int SH_A   = XS_SH_A,
    parameter int SH_B   = XS_SH_B,
    parameter int SH_C   = XS_SH_C
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              run,
    output logic [DATA_W-1:0] data,
    output logic              step_done
);

    logic [DATA_W-1:0] data_q;
    logic [1:0]        step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            step_q <= 2'd0;
        end else if (load) begin
            data_q <= seed;
            step_q <= 2'd0;
        end else if (run) begin
            data_q <= xs_step(data_q, step_q, SH_A, SH_B, SH_C);
            // Step counter wraps to 0 so the next word's chain starts cleanly.
            step_q <= (step_q == 2'd2) ? 2'd0 : step_q + 2'd1;
        end
    end

    assign data      = data_q;
    assign step_done = run && (step_q == 2'd2);

endmodule

// File: rtl/xorshift_rr_scheduler.sv
// Round-robin scheduler sharing one xorshift32 core between NUM_REQ requesters.
// Latency: accept edge E0 -> out_valid after E3; one word per 4 cycles unstalled.
// Backpressure: out_ready low holds out_valid/out_data/out_id stable in OUT.
//
// Ports: clk, rst (async active-high), bus (slave modport of
// xorshift_rr_scheduler_if: request grant, tagged word stream, done, busy).
module xorshift_rr_scheduler
    import xorshift_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = XS_DATA_W,
    parameter int LEN_W   = 9,
    parameter int SH_A    = XS_SH_A,
    parameter int SH_B    = XS_SH_B,
    parameter int SH_C    = XS_SH_C
)(
    input  logic                    clk,
    input  logic                    rst,
    xorshift_rr_scheduler_if.slave  bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t              state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     id_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    word_cnt_q;
    logic                out_valid_q;
    logic [NUM_REQ-1:0]  done_q;

    logic [ID_W-1:0]     grant_idx;
    logic                grant_found;
    logic [NUM_REQ-1:0]  grant_vec;
    logic                accept;
    logic [DATA_W-1:0]   acc_seed;
    logic [LEN_W-1:0]    acc_len;
    logic                core_run;
    logic                step_done;
    logic [DATA_W-1:0]   core_data;
    logic                last_word;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + ID_W'(1);
    endfunction

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && bus.req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // Grants are withheld during the done pulse so a completion and a new
    // grant never share a cycle, and held at zero while reset is asserted.
    always_comb begin
        grant_vec = '0;
        if (!rst && state_q == IDLE && done_q == '0 && grant_found)
            grant_vec[grant_idx] = 1'b1;
    end

    assign accept    = |(grant_vec & bus.req_valid);
    assign acc_seed  = bus.req_seed[grant_idx*DATA_W +: DATA_W];
    assign acc_len   = bus.req_len[grant_idx*LEN_W +: LEN_W];
    assign core_run  = (state_q == CAL);
    assign last_word = (word_cnt_q == len_q - LEN_W'(1));

    xorshift_rr_scheduler_core #(
        .DATA_W (DATA_W),
        .SH_A   (SH_A),
        .SH_B   (SH_B),
        .SH_C   (SH_C)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .seed      (acc_seed),
        .run       (core_run),
        .data      (core_data),
        .step_done (step_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q       <= grant_idx;
                        len_q      <= acc_len;
                        word_cnt_q <= '0;
                        if (acc_len == '0) begin
                            // Empty job completes immediately; the pointer
                            // still advances so it cannot monopolise grants.
                            done_q[grant_idx] <= 1'b1;
                            ptr_q             <= wrap_inc(grant_idx);
                        end else begin
                            state_q <= CAL;
                        end
                    end
                end
                CAL: begin
                    if (step_done) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        word_cnt_q  <= word_cnt_q + LEN_W'(1);
                        if (last_word) begin
                            done_q[id_q] <= 1'b1;
                            ptr_q        <= wrap_inc(id_q);
                            state_q      <= IDLE;
                        end else begin
                            // Next word chains from the current register value.
                            state_q <= CAL;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = grant_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = core_data;
    assign bus.out_id    = id_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
